keyb_entry: RTL and testbench
=============================

Name: keyb_entry

Overview:
- Consumer end of the keypad scanner interface. Takes the scanner's KeyRead level and BCDKey code and debounces them into single key events.
- Assembles digit keys into a multi-digit BCD operand. On an operator key it hands the operand and opcode to the calculator core over a valid/ready handshake.
- Sits between the keypad scanner and the ALU/control FSM. It also drives the live entry value to the display path.

Parameters:
- NDIGITS, 4, maximum BCD digits per operand.
- DEBOUNCE_CYCLES, 16, consecutive stable CLK cycles required to accept a press or a release (range 1..255).

Ports:
- CLK  input  1  system clock.
- RESET  input  1  reset.
- KeyRead  input  1  scanner level: a key is currently being held.
- BCDKey  input  4  scanner key code, valid while KeyRead=1.
- OpReady  input  1  core accepts Operand/OpCode this cycle.
- OpValid  output  1  Operand/OpCode valid, held until accepted.
- Operand  output  4*NDIGITS  BCD operand, least significant digit in [3:0].
- OpCode  output  3  0=ADD(0xA), 1=SUB(0xB), 2=MUL(0xC), 3=DIV(0xD), 4=EQU(0xE).
- Entry  output  4*NDIGITS  live BCD entry for the display.
- DigitCount  output  clog2(NDIGITS+1)  number of digits entered.
- KeyEvent  output  1  one-cycle pulse per accepted key.
- Overflow  output  1  one-cycle pulse: digit rejected because entry is full.
- Dropped  output  1  one-cycle pulse: key event discarded because OpValid=1.

Behaviour:
- Reset is asynchronous and active-high on RESET; clock is CLK, rising-edge.
- Reset values: all outputs are 0, the FSM is in IDLE and the debounce counter is 0. Assertion mid-operation aborts any handshake and clears Entry.
- Debounce FSM (registered):
  - IDLE: KeyRead=1 -> PRESS; latch BCDKey into key_r; cnt=1.
  - PRESS: KeyRead=0 -> IDLE. BCDKey!=key_r -> relatch key_r, cnt=1. Otherwise cnt++; when cnt reaches DEBOUNCE_CYCLES -> HELD.
  - HELD: on entry, key_evt pulses for 1 cycle with key_r. KeyRead=0 -> RELEASE with cnt=1.
  - RELEASE: KeyRead=1 -> HELD with no new event. Otherwise cnt++; at DEBOUNCE_CYCLES -> IDLE.
  - Exactly one event per physical press. Auto-repeat never occurs.
  - Latency: KeyEvent is high DEBOUNCE_CYCLES+1 cycles after KeyRead first rises, given stable input.
- KeyEvent mirrors key_evt in the same cycle as the datapath update.
- Entry datapath, acting on a key_evt cycle:
  - If OpValid=1: discard the event, pulse Dropped; Entry is unchanged.
  - Digit 0..9, DigitCount<NDIGITS: Entry <= {Entry[4N-5:0], digit}; DigitCount++.
    - Exception: digit 0 with DigitCount=0 is a leading zero. Entry stays 0, count stays 0, no Overflow.
  - Digit 0..9, DigitCount=NDIGITS: Entry is unchanged; pulse Overflow.
  - 0xA..0xE: Operand <= Entry; OpCode <= code-0xA; OpValid <= 1 on the next edge. Entry and DigitCount are not cleared yet.
  - 0xF (CLEAR): Entry <= 0, DigitCount <= 0. OpValid is unaffected.
- Handshake:
  - OpValid stays high, and Operand/OpCode stay stable, until a cycle with OpValid=1 && OpReady=1.
  - On that edge: OpValid <= 0, Entry <= 0, DigitCount <= 0.
  - OpReady while OpValid=0 is ignored.
  - A key_evt in the same cycle as the accepting handshake is Dropped, because OpValid=1 is still sampled.
- An operator key with DigitCount=0 still issues Operand=0. The core decides semantics.
- Overflow, Dropped and KeyEvent are mutually consistent: Overflow and Dropped only ever assert in a KeyEvent cycle.
- Invalid BCDKey values are impossible; all 16 codes are defined.

Test Plan:
- DEBOUNCE_CYCLES=4. KeyRead=1 with BCDKey=5, held 10 cycles, then released 10 cycles -> KeyEvent pulses once, 5 cycles after rise; Entry=0x0005; DigitCount=1.
- KeyRead glitches high for 2 cycles, then low -> no KeyEvent; Entry unchanged. Repeat with BCDKey changing 3->7 mid-press -> single event with key 7.
- NDIGITS=4. Press 0,1,2,3,4,5 -> the leading 0 is ignored; Entry=0x1234, DigitCount=4; key 5 pulses Overflow and Entry stays 0x1234.
- Entry=0x0042, press 0xB with OpReady=0 for 20 cycles, then OpReady=1 for 1 cycle -> OpValid held high with Operand=0x0042, OpCode=1; after acceptance OpValid=0, Entry=0, DigitCount=0.
- With OpValid=1, press 9 -> Dropped pulses and Entry is unchanged. Press 0xF at Entry=0x0017 with OpValid=0 -> Entry=0, DigitCount=0.
- Assert RESET during PRESS debounce and during OpValid=1 -> all outputs are 0 immediately (asynchronous). After release, a full press of key 8 yields Entry=0x0008.

Source files
------------

// File: rtl/keyb_entry.sv
// keyb_entry: keypad consumer. Debounces the scanner's KeyRead/BCDKey into
// single key events, builds a multi-digit BCD operand from digit keys and
// offers operand + opcode to the calculator core on an operator key.
//
// Handshake: OpValid/Operand/OpCode form a valid/ready source. Once OpValid
// rises, Operand and OpCode are frozen until a rising CLK edge where
// OpValid=1 and OpReady=1 both hold; that edge drops OpValid and clears the
// entry. OpReady is ignored while OpValid=0, and key events that arrive while
// OpValid=1 (including the accepting cycle) are discarded with a Dropped pulse.
module keyb_entry #(
    parameter int NDIGITS         = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         KeyRead,
    input  logic [3:0]                   BCDKey,
    input  logic                         OpReady,
    output logic                         OpValid,
    output logic [4*NDIGITS-1:0]         Operand,
    output logic [2:0]                   OpCode,
    output logic [4*NDIGITS-1:0]         Entry,
    output logic [$clog2(NDIGITS+1)-1:0] DigitCount,
    output logic                         KeyEvent,
    output logic                         Overflow,
    output logic                         Dropped
);

    localparam int W  = 4 * NDIGITS;
    localparam int CW = $clog2(NDIGITS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } deb_state_t;

    // Debounce FSM state; kept as a named signal so checkers can bind to it.
    deb_state_t deb_state;
    logic [7:0] cnt;
    logic [3:0] key_r;
    logic       key_evt;

    // Stability counter lookahead: "cnt reaches DEBOUNCE_CYCLES" on this edge.
    logic [8:0] cnt_next;
    logic       cnt_done;
    assign cnt_next = {1'b0, cnt} + 9'd1;
    assign cnt_done = (cnt_next >= 9'(DEBOUNCE_CYCLES));

    // Opcode is the operator key code offset from 0xA.
    logic [3:0] opc_full;
    assign opc_full = key_r - 4'hA;

    logic digit_key;
    logic entry_full;
    assign digit_key  = (key_r <= 4'd9);
    assign entry_full = (DigitCount == CW'(NDIGITS));

    // Debounce FSM: one key_evt pulse per press, on entry to HELD.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            deb_state <= IDLE;
            cnt       <= 8'd0;
            key_r     <= 4'd0;
            key_evt   <= 1'b0;
        end else begin
            key_evt <= 1'b0;
            case (deb_state)
                IDLE: begin
                    if (KeyRead) begin
                        key_r <= BCDKey;
                        cnt   <= 8'd1;
                        // A single stable sample is already enough here.
                        if (DEBOUNCE_CYCLES <= 1) begin
                            deb_state <= HELD;
                            key_evt   <= 1'b1;
                        end else begin
                            deb_state <= PRESS;
                        end
                    end
                end
                PRESS: begin
                    if (!KeyRead) begin
                        deb_state <= IDLE;
                        cnt       <= 8'd0;
                    end else if (BCDKey != key_r) begin
                        // Code changed mid-press: restart on the new code.
                        key_r <= BCDKey;
                        cnt   <= 8'd1;
                    end else if (cnt_done) begin
                        deb_state <= HELD;
                        key_evt   <= 1'b1;
                        cnt       <= 8'd0;
                    end else begin
                        cnt <= cnt_next[7:0];
                    end
                end
                HELD: begin
                    if (!KeyRead) begin
                        deb_state <= RELEASE;
                        cnt       <= 8'd1;
                    end
                end
                RELEASE: begin
                    if (KeyRead) begin
                        // Bounce during release: back to HELD, no new event.
                        deb_state <= HELD;
                        cnt       <= 8'd0;
                    end else if (cnt_done) begin
                        deb_state <= IDLE;
                        cnt       <= 8'd0;
                    end else begin
                        cnt <= cnt_next[7:0];
                    end
                end
                default: begin
                    deb_state <= IDLE;
                    cnt       <= 8'd0;
                end
            endcase
        end
    end

    // Entry datapath and operand handshake, acting on debounced key events.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OpValid    <= 1'b0;
            Operand    <= '0;
            OpCode     <= 3'd0;
            Entry      <= '0;
            DigitCount <= '0;
            KeyEvent   <= 1'b0;
            Overflow   <= 1'b0;
            Dropped    <= 1'b0;
        end else begin
            KeyEvent <= key_evt;
            Overflow <= 1'b0;
            Dropped  <= 1'b0;

            if (OpValid && OpReady) begin
                OpValid    <= 1'b0;
                Entry      <= '0;
                DigitCount <= '0;
            end

            if (key_evt) begin
                if (OpValid) begin
                    Dropped <= 1'b1;
                end else if (digit_key) begin
                    if (entry_full) begin
                        Overflow <= 1'b1;
                    end else if (!(key_r == 4'd0 && DigitCount == '0)) begin
                        Entry      <= {Entry[W-5:0], key_r};
                        DigitCount <= DigitCount + CW'(1);
                    end
                end else if (key_r != 4'hF) begin
                    Operand <= Entry;
                    OpCode  <= opc_full[2:0];
                    OpValid <= 1'b1;
                end else begin
                    Entry      <= '0;
                    DigitCount <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keyb_entry.sv
// tb_keyb_entry: directed tests for keyb_entry with DEBOUNCE_CYCLES=4, NDIGITS=4.
module tb_keyb_entry;

    logic        CLK;
    logic        RESET;
    logic        KeyRead;
    logic [3:0]  BCDKey;
    logic        OpReady;
    logic        OpValid;
    logic [15:0] Operand;
    logic [2:0]  OpCode;
    logic [15:0] Entry;
    logic [2:0]  DigitCount;
    logic        KeyEvent;
    logic        Overflow;
    logic        Dropped;

    int n_checks = 0;
    int n_fail   = 0;
    int evt_cnt  = 0;
    int ovf_cnt  = 0;
    int drp_cnt  = 0;

    keyb_entry #(.NDIGITS(4), .DEBOUNCE_CYCLES(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .KeyRead    (KeyRead),
        .BCDKey     (BCDKey),
        .OpReady    (OpReady),
        .OpValid    (OpValid),
        .Operand    (Operand),
        .OpCode     (OpCode),
        .Entry      (Entry),
        .DigitCount (DigitCount),
        .KeyEvent   (KeyEvent),
        .Overflow   (Overflow),
        .Dropped    (Dropped)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulse counters, sampled away from the active edge
    always @(negedge CLK) begin
        if (!RESET) begin
            if (KeyEvent) evt_cnt++;
            if (Overflow) ovf_cnt++;
            if (Dropped)  drp_cnt++;
        end
    end

    // Driver: a clean press held 8 cycles, then released 8 cycles
    task automatic press_key(input logic [3:0] code);
        @(negedge CLK);
        KeyRead = 1'b1;
        BCDKey  = code;
        repeat (8) @(negedge CLK);
        KeyRead = 1'b0;
        repeat (8) @(negedge CLK);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({OpValid, Operand, OpCode, Entry, DigitCount, KeyEvent, Overflow, Dropped} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ov=%0b op=%h oc=%0d en=%h dc=%0d ke=%0b of=%0b dr=%0b, want all 0",
                     OpValid, Operand, OpCode, Entry, DigitCount, KeyEvent, Overflow, Dropped);
        end
    endtask

    task automatic test_debounce_latency();
        int e0;
        e0 = evt_cnt;
        @(negedge CLK);
        KeyRead = 1'b1;
        BCDKey  = 4'd5;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            n_checks++;
            if (KeyEvent !== (i == 5)) begin
                n_fail++;
                $display("FAIL latency_cycle%0d: KeyEvent=%0b want %0b", i, KeyEvent, (i == 5));
            end
        end
        KeyRead = 1'b0;
        repeat (10) @(negedge CLK);
        n_checks++;
        if (evt_cnt - e0 != 1) begin
            n_fail++;
            $display("FAIL single_event: events=%0d want 1", evt_cnt - e0);
        end
        n_checks++;
        if (Entry !== 16'h0005 || DigitCount !== 3'd1) begin
            n_fail++;
            $display("FAIL entry_5: Entry=%h DigitCount=%0d want 0005/1", Entry, DigitCount);
        end
        press_key(4'hF);
    endtask

    task automatic test_glitch();
        int e0;
        e0 = evt_cnt;
        @(negedge CLK);
        KeyRead = 1'b1;
        BCDKey  = 4'd6;
        repeat (2) @(negedge CLK);
        KeyRead = 1'b0;
        repeat (10) @(negedge CLK);
        n_checks++;
        if (evt_cnt != e0 || Entry !== 16'h0000) begin
            n_fail++;
            $display("FAIL glitch: events=%0d Entry=%h want 0/0000", evt_cnt - e0, Entry);
        end
        // Code changes 3 -> 7 mid-press
        KeyRead = 1'b1;
        BCDKey  = 4'd3;
        repeat (2) @(negedge CLK);
        BCDKey = 4'd7;
        repeat (8) @(negedge CLK);
        KeyRead = 1'b0;
        repeat (8) @(negedge CLK);
        n_checks++;
        if (evt_cnt - e0 != 1 || Entry !== 16'h0007 || DigitCount !== 3'd1) begin
            n_fail++;
            $display("FAIL key_change: events=%0d Entry=%h dc=%0d want 1/0007/1", evt_cnt - e0, Entry, DigitCount);
        end
        press_key(4'hF);
    endtask

    task automatic test_digits();
        int o0;
        o0 = ovf_cnt;
        press_key(4'd0);
        n_checks++;
        if (Entry !== 16'h0000 || DigitCount !== 3'd0) begin
            n_fail++;
            $display("FAIL leading_zero: Entry=%h dc=%0d want 0000/0", Entry, DigitCount);
        end
        press_key(4'd1);
        press_key(4'd2);
        press_key(4'd3);
        press_key(4'd4);
        n_checks++;
        if (Entry !== 16'h1234 || DigitCount !== 3'd4 || ovf_cnt != o0) begin
            n_fail++;
            $display("FAIL entry_1234: Entry=%h dc=%0d ovf=%0d want 1234/4/0", Entry, DigitCount, ovf_cnt - o0);
        end
        press_key(4'd5);
        n_checks++;
        if (Entry !== 16'h1234 || DigitCount !== 3'd4 || ovf_cnt - o0 != 1) begin
            n_fail++;
            $display("FAIL overflow: Entry=%h dc=%0d ovf=%0d want 1234/4/1", Entry, DigitCount, ovf_cnt - o0);
        end
        press_key(4'hF);
    endtask

    task automatic test_handshake();
        int d0;
        int bad;
        OpReady = 1'b0;
        press_key(4'd4);
        press_key(4'd2);
        // OpReady while idle must not clear the entry
        @(negedge CLK);
        OpReady = 1'b1;
        @(negedge CLK);
        OpReady = 1'b0;
        n_checks++;
        if (Entry !== 16'h0042 || OpValid !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_ignored: Entry=%h OpValid=%0b want 0042/0", Entry, OpValid);
        end
        press_key(4'hB);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (OpValid !== 1'b1 || Operand !== 16'h0042 || OpCode !== 3'd1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_valid: %0d bad cycles, last ov=%0b op=%h oc=%0d want 1/0042/1",
                     bad, OpValid, Operand, OpCode);
        end
        d0 = drp_cnt;
        press_key(4'd9);
        n_checks++;
        if (drp_cnt - d0 != 1 || Entry !== 16'h0042 || OpValid !== 1'b1) begin
            n_fail++;
            $display("FAIL dropped: drops=%0d Entry=%h ov=%0b want 1/0042/1", drp_cnt - d0, Entry, OpValid);
        end
        OpReady = 1'b1;
        @(negedge CLK);
        OpReady = 1'b0;
        n_checks++;
        if (OpValid !== 1'b0 || Entry !== 16'h0000 || DigitCount !== 3'd0) begin
            n_fail++;
            $display("FAIL accept: ov=%0b Entry=%h dc=%0d want 0/0000/0", OpValid, Entry, DigitCount);
        end
        // Operator with empty entry issues operand 0
        press_key(4'hE);
        n_checks++;
        if (OpValid !== 1'b1 || Operand !== 16'h0000 || OpCode !== 3'd4) begin
            n_fail++;
            $display("FAIL empty_equ: ov=%0b op=%h oc=%0d want 1/0000/4", OpValid, Operand, OpCode);
        end
        OpReady = 1'b1;
        @(negedge CLK);
        OpReady = 1'b0;
    endtask

    task automatic test_clear();
        press_key(4'd1);
        press_key(4'd7);
        n_checks++;
        if (Entry !== 16'h0017) begin
            n_fail++;
            $display("FAIL entry_17: Entry=%h want 0017", Entry);
        end
        press_key(4'hF);
        n_checks++;
        if (Entry !== 16'h0000 || DigitCount !== 3'd0 || OpValid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear: Entry=%h dc=%0d ov=%0b want 0000/0/0", Entry, DigitCount, OpValid);
        end
    endtask

    task automatic test_reset_mid();
        press_key(4'd3);
        @(negedge CLK);
        KeyRead = 1'b1;
        BCDKey  = 4'd8;
        @(negedge CLK);
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        n_checks++;
        if ({OpValid, Operand, OpCode, Entry, DigitCount, KeyEvent, Overflow, Dropped} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_in_press: ov=%0b op=%h oc=%0d en=%h dc=%0d want all 0",
                     OpValid, Operand, OpCode, Entry, DigitCount);
        end
        @(negedge CLK);
        KeyRead = 1'b0;
        RESET   = 1'b0;
        repeat (2) @(negedge CLK);
        press_key(4'd5);
        press_key(4'hA);
        n_checks++;
        if (OpValid !== 1'b1 || Operand !== 16'h0005 || OpCode !== 3'd0) begin
            n_fail++;
            $display("FAIL add_issue: ov=%0b op=%h oc=%0d want 1/0005/0", OpValid, Operand, OpCode);
        end
        @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        n_checks++;
        if ({OpValid, Operand, OpCode, Entry, DigitCount, KeyEvent, Overflow, Dropped} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_in_valid: ov=%0b op=%h oc=%0d en=%h dc=%0d want all 0",
                     OpValid, Operand, OpCode, Entry, DigitCount);
        end
        @(negedge CLK);
        RESET = 1'b0;
        press_key(4'd8);
        n_checks++;
        if (Entry !== 16'h0008 || DigitCount !== 3'd1 || OpValid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: Entry=%h dc=%0d ov=%0b want 0008/1/0", Entry, DigitCount, OpValid);
        end
    endtask

    initial begin
        RESET   = 1'b1;
        KeyRead = 1'b0;
        BCDKey  = 4'd0;
        OpReady = 1'b0;
        repeat (3) @(negedge CLK);
        test_reset();
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        test_debounce_latency();
        test_glitch();
        test_digits();
        test_handshake();
        test_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
